fft_ram_sequencer: RTL
======================

// Module: fft_ram_sequencer
// PURPOSE
//  Sequences in-place radix-2 DIT FFT passes over the dual-port real/imag data RAMs.
//  Per butterfly: drives both RAM address ports, the twiddle ROM address and the write enables.
//  Tells the external butterfly datapath when read data is valid and when its result is written.
//  Sits between the top-level spectrum_analyzer control (start/done) and the data RAM pair.
// PARAMETERS
//  RAM_ADDR_BITS  10  log2(N); N = 2**RAM_ADDR_BITS points, stage count = RAM_ADDR_BITS
//  BFLY_LAT       4   butterfly datapath latency, read-data-valid to result-valid; >= 1
//  STAGE_BITS     4   width of stage output; 2**STAGE_BITS must be > RAM_ADDR_BITS
// PORTS
//  Clk            in   1              single clock, all logic on posedge
//  reset          in   1              synchronous, active-high
//  start          in   1              1-cycle request to run a full FFT; ignored while busy
//  busy           out  1              high from cycle after accepted start until done
//  done           out  1              1-cycle pulse after last write
//  stage          out  STAGE_BITS     current stage s, 0..RAM_ADDR_BITS-1
//  addrA          out  RAM_ADDR_BITS  RAM port A address (top/even leg)
//  addrB          out  RAM_ADDR_BITS  RAM port B address (bottom/odd leg)
//  write_enableA  out  1              RAM port A write enable
//  write_enableB  out  1              RAM port B write enable
//  tw_addr        out  RAM_ADDR_BITS-1  twiddle ROM index
//  bfly_in_valid  out  1              DoutA/DoutB hold valid butterfly operands this cycle
//  swap           out  1              datapath routes DoutB->DinA, DoutA->DinB (bitrev only)
// BEHAVIOUR
//  RAM timing: address registered in RAM; data readable the cycle after address is driven.
//  A write lands at the address driven the previous cycle. Addresses are held per butterfly.
//  Reset: every output 0; FSM -> IDLE; counters cleared. Reset mid-run aborts immediately.
//  RAM contents after an abort are undefined; caller restarts.
//  FSM: IDLE -start-> [BREV] -> RD -> DATA -> WAIT -> WR -> (next bfly RD | next stage RD | DONE)
//  Butterfly k in stage s, span = 1<<s:
//    addrA = ((k>>s)<<(s+1)) | (k & (span-1)); addrB = addrA | span.
//    tw_addr = (k & (span-1)) << (RAM_ADDR_BITS-1-s).
//  Cycle c0 = RD: drive addrA/addrB/tw_addr. c1 = DATA: bfly_in_valid=1.
//  c1+BFLY_LAT = WR: write_enableA=write_enableB=1, both for exactly one cycle. WAIT fills the gap.
//  Cost per butterfly = BFLY_LAT+2 cycles; no overlap between butterflies (no RAW hazard).
//  k runs 0..N/2-1, then s increments. After s=RAM_ADDR_BITS-1, k=N/2-1 WR -> DONE (1 cyc).
//  In DONE: done=1, busy=0 next cycle, then -> IDLE.
//  start asserted on the DONE cycle is ignored; it is accepted only in IDLE.
//  Input data is already bit-reversed in RAM unless FFT_BITREV_EN is defined.
//  Counters: k is RAM_ADDR_BITS-1 bits and wraps to 0 at stage end; no other wrap.
// CONFIGURATION
//  `define FFT_BITREV_EN: adds state BREV before stage 0, an in-place bit-reverse permutation.
//    For each i < rev(i): cycle 0 drives addrA=i, addrB=rev(i).
//    Cycle 1: swap=1, write_enableA=write_enableB=1 (read and swapped write on the same edge).
//    i == rev(i) costs 0 cycles. stage=0, bfly_in_valid=0 throughout.
//  Undefined: no BREV state; swap tied 0; data must be loaded bit-reversed.
// STRUCTURE
//  Package fft_seq_pkg: FSM state encoding, bitrev(i, bits) function, addr/twiddle functions.
//  Sub-module fft_bfly_addr_gen: combinational (s, k) -> addrA, addrB, tw_addr; outputs registered in parent.
// TESTING (RAM_ADDR_BITS=3, BFLY_LAT=1 unless noted)
//  1. reset held 3 cyc, then release -> all outputs 0, busy=0.
//  2. start -> stage0 k=0: addrA=0 addrB=1 tw=0; stage2 k=1: addrA=1 addrB=5 tw=1; stage1 k=3: addrA=5 addrB=7 tw=2.
//  3. full run -> busy high 36 cyc (3*4*3), write enables high 12 cyc, 1-cycle done pulse.
//  4. start pulsed while busy and on the DONE cycle -> no restart; one done only.
//  5. reset asserted mid stage1 -> next cycle all outputs 0, IDLE; new start reruns from stage0 k=0.
//  6. FFT_BITREV_EN -> swaps (1,4),(3,6) with swap=1; busy 40 cyc; RAM ramp 0..7 -> 0,4,2,6,1,5,3,7 before stage0.

Source files
------------

// File: rtl/fft_seq_pkg.sv
// Shared FSM encoding and address helpers for the in-place radix-2 DIT FFT sequencer.
// The bit-reverse helper only drives hardware when FFT_BITREV_EN is defined.
package fft_seq_pkg;

   localparam int unsigned MAX_BITS = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_BREV_RD,
      ST_BREV_WR,
      ST_RD,
      ST_DATA,
      ST_WAIT,
      ST_WR,
      ST_DONE
   } seq_state_t;

   // Reverse the low 'bits' bits of v.
   function automatic logic [MAX_BITS-1:0] bitrev(input logic [MAX_BITS-1:0] v,
                                                  input int unsigned bits);
      logic [MAX_BITS-1:0] r;
      r = '0;
      for (int unsigned j = 0; j < MAX_BITS; j++) begin
         if (j < bits) begin
            r = r | (((v >> j) & MAX_BITS'(1)) << (bits - 1 - j));
         end
      end
      return r;
   endfunction

   function automatic logic [MAX_BITS-1:0] span_of(input int unsigned s);
      return MAX_BITS'(1) << s;
   endfunction

   // Top leg: insert a zero at bit position s of k.
   function automatic logic [MAX_BITS-1:0] bfly_addr_a(input int unsigned s,
                                                       input logic [MAX_BITS-1:0] k);
      return ((k >> s) << (s + 1)) | (k & (span_of(s) - MAX_BITS'(1)));
   endfunction

   function automatic logic [MAX_BITS-1:0] bfly_addr_b(input int unsigned s,
                                                       input logic [MAX_BITS-1:0] k);
      return bfly_addr_a(s, k) | span_of(s);
   endfunction

   function automatic logic [MAX_BITS-1:0] tw_index(input int unsigned s,
                                                    input logic [MAX_BITS-1:0] k,
                                                    input int unsigned bits);
      return (k & (span_of(s) - MAX_BITS'(1))) << (bits - 1 - s);
   endfunction

endpackage

// File: rtl/fft_bfly_addr_gen.sv
// Combinational (stage, butterfly index) -> RAM leg addresses and twiddle ROM index.
module fft_bfly_addr_gen
   import fft_seq_pkg::*;
#(
   parameter int unsigned RAM_ADDR_BITS = 10,
   parameter int unsigned STAGE_BITS    = 4
) (
   input  logic [STAGE_BITS-1:0]    s,
   input  logic [RAM_ADDR_BITS-2:0] k,
   output logic [RAM_ADDR_BITS-1:0] addr_a_c,
   output logic [RAM_ADDR_BITS-1:0] addr_b_c,
   output logic [RAM_ADDR_BITS-2:0] tw_addr_c
);

   always_comb begin
      addr_a_c  = RAM_ADDR_BITS'(bfly_addr_a(32'(s), MAX_BITS'(k)));
      addr_b_c  = RAM_ADDR_BITS'(bfly_addr_b(32'(s), MAX_BITS'(k)));
      tw_addr_c = (RAM_ADDR_BITS-1)'(tw_index(32'(s), MAX_BITS'(k), RAM_ADDR_BITS));
   end

endmodule

// File: rtl/fft_ram_sequencer.sv
// Sequences in-place radix-2 DIT FFT passes over the dual-port data RAMs.
// Define FFT_BITREV_EN to add an in-place bit-reverse permutation pass before stage 0.
module fft_ram_sequencer
   import fft_seq_pkg::*;
#(
   parameter int unsigned RAM_ADDR_BITS = 10,
   parameter int unsigned BFLY_LAT      = 4,
   parameter int unsigned STAGE_BITS    = 4
) (
   input  logic                     Clk,
   input  logic                     reset,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic [STAGE_BITS-1:0]    stage,
   output logic [RAM_ADDR_BITS-1:0] addrA,
   output logic [RAM_ADDR_BITS-1:0] addrB,
   output logic                     write_enableA,
   output logic                     write_enableB,
   output logic [RAM_ADDR_BITS-2:0] tw_addr,
   output logic                     bfly_in_valid,
   output logic                     swap
);

   localparam int unsigned K_BITS    = RAM_ADDR_BITS - 1;
   localparam int unsigned WAIT_BITS = (BFLY_LAT > 2) ? $clog2(BFLY_LAT) : 1;

   seq_state_t             state, state_nxt;
   logic [STAGE_BITS-1:0]  s_q, s_nxt;
   logic [K_BITS-1:0]      k_q, k_nxt;
   logic [WAIT_BITS-1:0]   w_q, w_nxt;

   logic [RAM_ADDR_BITS-1:0] gen_a_c, gen_b_c;
   logic [K_BITS-1:0]        gen_tw_c;

   logic                     busy_nxt, done_nxt, valid_nxt, we_nxt, swap_nxt;
   logic [STAGE_BITS-1:0]    stage_nxt;
   logic [RAM_ADDR_BITS-1:0] addr_a_nxt, addr_b_nxt;
   logic [K_BITS-1:0]        tw_nxt;

`ifdef FFT_BITREV_EN
   localparam int unsigned N         = 1 << RAM_ADDR_BITS;
   localparam int unsigned BASE_BITS = RAM_ADDR_BITS + 1;

   logic [RAM_ADDR_BITS-1:0] i_q, i_nxt;
   logic [BASE_BITS-1:0]     srch_base_c;
   logic                     found_c;
   logic [RAM_ADDR_BITS-1:0] found_idx_c;

   // Next index at or above the base that needs a swap; self-reversed indices cost nothing.
   always_comb begin
      srch_base_c = (state == ST_IDLE) ? '0 : BASE_BITS'(i_q) + BASE_BITS'(1);
      found_c     = 1'b0;
      found_idx_c = '0;
      for (int j = int'(N) - 1; j >= 0; j--) begin
         if ((BASE_BITS'(j) >= srch_base_c) &&
             (MAX_BITS'(j) < bitrev(MAX_BITS'(j), RAM_ADDR_BITS))) begin
            found_c     = 1'b1;
            found_idx_c = RAM_ADDR_BITS'(j);
         end
      end
   end
`endif

   fft_bfly_addr_gen #(
      .RAM_ADDR_BITS(RAM_ADDR_BITS),
      .STAGE_BITS   (STAGE_BITS)
   ) u_addr_gen (
      .s        (s_nxt),
      .k        (k_nxt),
      .addr_a_c (gen_a_c),
      .addr_b_c (gen_b_c),
      .tw_addr_c(gen_tw_c)
   );

   // Next-state and counter update.
   always_comb begin
      state_nxt = state;
      s_nxt     = s_q;
      k_nxt     = k_q;
      w_nxt     = w_q;
`ifdef FFT_BITREV_EN
      i_nxt     = i_q;
`endif
      case (state)
         ST_IDLE: begin
            if (start) begin
               s_nxt = '0;
               k_nxt = '0;
`ifdef FFT_BITREV_EN
               if (found_c) begin
                  state_nxt = ST_BREV_RD;
                  i_nxt     = found_idx_c;
               end else begin
                  state_nxt = ST_RD;
               end
`else
               state_nxt = ST_RD;
`endif
            end
         end
`ifdef FFT_BITREV_EN
         ST_BREV_RD: state_nxt = ST_BREV_WR;
         ST_BREV_WR: begin
            if (found_c) begin
               state_nxt = ST_BREV_RD;
               i_nxt     = found_idx_c;
            end else begin
               state_nxt = ST_RD;
            end
         end
`endif
         ST_RD: state_nxt = ST_DATA;
         ST_DATA: begin
            w_nxt     = '0;
            state_nxt = (BFLY_LAT > 1) ? ST_WAIT : ST_WR;
         end
         ST_WAIT: begin
            if (32'(w_q) >= BFLY_LAT - 2) begin
               state_nxt = ST_WR;
            end else begin
               w_nxt = w_q + WAIT_BITS'(1);
            end
         end
         ST_WR: begin
            state_nxt = ST_RD;
            if (k_q == '1) begin
               k_nxt = '0;
               if (32'(s_q) == RAM_ADDR_BITS - 1) begin
                  state_nxt = ST_DONE;
               end else begin
                  s_nxt = s_q + STAGE_BITS'(1);
               end
            end else begin
               k_nxt = k_q + K_BITS'(1);
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Output decode from the state being entered, so outputs line up with their state.
   always_comb begin
      busy_nxt   = 1'b0;
      done_nxt   = 1'b0;
      valid_nxt  = 1'b0;
      we_nxt     = 1'b0;
      swap_nxt   = 1'b0;
      stage_nxt  = '0;
      addr_a_nxt = '0;
      addr_b_nxt = '0;
      tw_nxt     = '0;
      case (state_nxt)
         ST_RD, ST_DATA, ST_WAIT, ST_WR: begin
            busy_nxt   = 1'b1;
            stage_nxt  = s_nxt;
            addr_a_nxt = gen_a_c;
            addr_b_nxt = gen_b_c;
            tw_nxt     = gen_tw_c;
            valid_nxt  = (state_nxt == ST_DATA);
            we_nxt     = (state_nxt == ST_WR);
         end
`ifdef FFT_BITREV_EN
         ST_BREV_RD, ST_BREV_WR: begin
            busy_nxt   = 1'b1;
            addr_a_nxt = i_nxt;
            addr_b_nxt = RAM_ADDR_BITS'(bitrev(MAX_BITS'(i_nxt), RAM_ADDR_BITS));
            swap_nxt   = (state_nxt == ST_BREV_WR);
            we_nxt     = (state_nxt == ST_BREV_WR);
         end
`endif
         ST_DONE: done_nxt = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         state <= ST_IDLE;
         s_q   <= '0;
         k_q   <= '0;
         w_q   <= '0;
`ifdef FFT_BITREV_EN
         i_q   <= '0;
`endif
      end else begin
         state <= state_nxt;
         s_q   <= s_nxt;
         k_q   <= k_nxt;
         w_q   <= w_nxt;
`ifdef FFT_BITREV_EN
         i_q   <= i_nxt;
`endif
      end
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         busy          <= 1'b0;
         done          <= 1'b0;
         stage         <= '0;
         addrA         <= '0;
         addrB         <= '0;
         write_enableA <= 1'b0;
         write_enableB <= 1'b0;
         tw_addr       <= '0;
         bfly_in_valid <= 1'b0;
         swap          <= 1'b0;
      end else begin
         busy          <= busy_nxt;
         done          <= done_nxt;
         stage         <= stage_nxt;
         addrA         <= addr_a_nxt;
         addrB         <= addr_b_nxt;
         write_enableA <= we_nxt;
         write_enableB <= we_nxt;
         tw_addr       <= tw_nxt;
         bfly_in_valid <= valid_nxt;
         swap          <= swap_nxt;
      end
   end

endmodule
